// File: rtl/aes_key_expand.sv
// Sequential AES-128/192/256 key expansion: one schedule word per advance,
// packed into 128-bit round keys behind a valid/ready handshake.
module aes_key_expand #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key_i,
  input  logic                    abort,
  output logic [31:0]             sub_o,
  input  logic [31:0]             sub_i,
  output logic [127:0]            rk_o,
  output logic [3:0]              rk_idx,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic                    rk_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int PAD = 256 - MAX_KEY_BITS;

  typedef enum logic [1:0] {IDLE, KEYW, EXPAND, FLUSH} state_t;

  state_t        state, state_nx;
  logic [255:0]  key_sh;
  logic [255:0]  key_ext;
  logic [3:0]    nk, nr, nk_req, nr_req;
  logic [5:0]    idx;
  logic [2:0]    j;
  logic [7:0]    rcon;
  logic [1:0]    cnt;
  logic [3:0]    round;
  logic [95:0]   buf_q;
  logic [31:0]   win [8];
  logic [31:0]   prev, old, temp, w;
  logic          legal, producing, adv, accept, j_last, last_word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  assign key_ext   = 256'(key_i) << PAD;
  assign nk_req    = 4'd4 + {1'b0, key_len, 1'b0};
  assign nr_req    = 4'd10 + {1'b0, key_len, 1'b0};
  assign legal     = (key_len != 2'd3) && ((int'(nk_req) * 32) <= MAX_KEY_BITS);
  assign producing = (state == KEYW) || (state == EXPAND);
  assign accept    = rk_valid && rk_ready;
  // A word may only be produced if the 4th-word slot has somewhere to go.
  assign adv       = producing && ((cnt != 2'd3) || !rk_valid || rk_ready);
  assign j_last    = ({1'b0, j} == (nk - 4'd1));
  assign last_word = (idx == {nr, 2'b11});
  assign busy      = (state != IDLE);

  assign prev = win[0];
  assign old  = win[3'(nk - 4'd1)];

  always_comb begin
    sub_o = (j == 3'd0) ? rot_word(prev) : prev;
    if (j == 3'd0)
      temp = sub_i ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j == 3'd4)
      temp = sub_i;
    else
      temp = prev;
    w = (state == KEYW) ? key_sh[255:224] : (old ^ temp);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && legal) state_nx = KEYW;
      KEYW:    if (abort) state_nx = IDLE;
               else if (adv && j_last) state_nx = EXPAND;
      EXPAND:  if (abort) state_nx = IDLE;
               else if (adv && last_word) state_nx = FLUSH;
      FLUSH:   if (abort || accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sh   <= '0;
      nk       <= '0;
      nr       <= '0;
      idx      <= '0;
      j        <= '0;
      rcon     <= '0;
      cnt      <= '0;
      round    <= '0;
      buf_q    <= '0;
      rk_o     <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (legal) begin
            key_sh <= key_ext;
            nk     <= nk_req;
            nr     <= nr_req;
            rcon   <= 8'h01;
            idx    <= '0;
            j      <= '0;
            cnt    <= '0;
            round  <= '0;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (abort) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
        idx      <= '0;
        j        <= '0;
        cnt      <= '0;
        round    <= '0;
        rcon     <= '0;
      end else if (adv) begin
        key_sh <= key_sh << 32;
        win[0] <= w;
        for (int k = 1; k < 8; k++) win[k] <= win[k-1];
        idx <= idx + 6'd1;
        j   <= j_last ? 3'd0 : j + 3'd1;
        cnt <= cnt + 2'd1;
        if (state == EXPAND && j == 3'd0) rcon <= xtime(rcon);
        if (cnt == 2'd3) begin
          // Loading here also covers a same-edge acceptance (zero bubble).
          rk_o     <= {buf_q, w};
          rk_valid <= 1'b1;
          rk_idx   <= round;
          rk_last  <= (round == nr);
          round    <= round + 4'd1;
        end else begin
          buf_q <= {buf_q[63:0], w};
          if (accept) rk_valid <= 1'b0;
        end
      end else if (accept) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
        if (state == FLUSH) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors plus random keys and back-pressure
// against a textbook key-schedule model, on 256-bit and 128-bit builds.
module tb_aes_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] key_i;

  logic [31:0]  sub_o_a, sub_i_a, sub_o_b, sub_i_b;
  logic [127:0] rk_o_a, rk_o_b;
  logic [3:0]   rk_idx_a, rk_idx_b;
  logic         rk_valid_a, rk_last_a, busy_a, done_a, err_a;
  logic         rk_valid_b, rk_last_b, busy_b, done_b, err_b;

  aes_key_expand #(.MAX_KEY_BITS(256)) dut_a (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_i(key_i),
    .abort(abort), .sub_o(sub_o_a), .sub_i(sub_i_a), .rk_o(rk_o_a),
    .rk_idx(rk_idx_a), .rk_valid(rk_valid_a), .rk_ready(rk_ready),
    .rk_last(rk_last_a), .busy(busy_a), .done(done_a), .err(err_a));

  aes_key_expand #(.MAX_KEY_BITS(128)) dut_b (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_i(key_i[255:128]),
    .abort(abort), .sub_o(sub_o_b), .sub_i(sub_i_b), .rk_o(rk_o_b),
    .rk_idx(rk_idx_b), .rk_valid(rk_valid_b), .rk_ready(rk_ready),
    .rk_last(rk_last_b), .busy(busy_b), .done(done_b), .err(err_b));

  int total = 0;
  int bad = 0;
  int zb_cnt = 0;
  bit sel = 1'b0;
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];

  logic [127:0] m_rk_o;
  logic [3:0]   m_idx;
  logic         m_valid, m_last, m_busy, m_done;

  // GF(2^8) arithmetic for an S-box derived from its definition.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r = 8'h01;
    logic [7:0] p = b;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  always_comb sub_i_a = subw(sub_o_a);
  always_comb sub_i_b = subw(sub_o_b);

  always_comb begin
    m_rk_o  = sel ? rk_o_b     : rk_o_a;
    m_idx   = sel ? rk_idx_b   : rk_idx_a;
    m_valid = sel ? rk_valid_b : rk_valid_a;
    m_last  = sel ? rk_last_b  : rk_last_a;
    m_busy  = sel ? busy_b     : busy_a;
    m_done  = sel ? done_b     : done_a;
  end

  task automatic model(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*nr+4; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: rk_ready always high; mode 1: random ready. poke: start while busy.
  task automatic run_job(input logic [255:0] key, input logic [1:0] kl, input int mode,
                         input bit timing, input bit poke);
    int nr = 10 + 2*kl;
    int nxt = 0, e = 0, first_v = -1, last_e = -1;
    bit fin = 1'b0, spurious = 1'b0, acc, was_v, was_last;
    logic [127:0] was_rk;
    logic [3:0] was_idx;
    model(key, 4 + 2*kl);
    key_len = kl; key_i = key; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && e < 400) begin
      if (poke && e == 10) begin
        start = 1'b1; key_len = 2'd2; key_i = ~key;
      end else begin
        start = 1'b0;
      end
      rk_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 35);
      was_v = m_valid; was_rk = m_rk_o; was_idx = m_idx; was_last = m_last;
      acc = was_v && rk_ready;
      if (acc && nxt < 15) begin
        total++;
        if (was_idx !== 4'(nxt) || was_rk !== exp_rk[nxt] || was_last !== (nxt == nr)) begin
          bad++;
          $display("FAIL rk_accept: got idx=%0d rk=%h last=%b, want idx=%0d rk=%h last=%b",
                   was_idx, was_rk, was_last, nxt, exp_rk[nxt], nxt == nr);
        end
        got_rk[nxt] = was_rk;
        nxt++;
      end
      tick();
      e++;
      if (first_v < 0 && m_valid) first_v = e;
      if (last_e < 0 && m_valid && m_last) last_e = e;
      if (was_v && !acc) begin
        total++;
        if (m_valid !== 1'b1 || m_rk_o !== was_rk || m_idx !== was_idx) begin
          bad++;
          $display("FAIL stall_hold: got v=%b idx=%0d rk=%h, want v=1 idx=%0d rk=%h",
                   m_valid, m_idx, m_rk_o, was_idx, was_rk);
        end
      end
      if (acc && m_valid && m_idx == was_idx + 4'd1) zb_cnt++;
      if (acc && was_last) begin
        fin = 1'b1;
        total++;
        if (m_done !== 1'b1 || m_busy !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse: got done=%b busy=%b, want done=1 busy=0", m_done, m_busy);
        end
      end else if (m_done !== 1'b0) begin
        spurious = 1'b1;
      end
    end
    start = 1'b0; rk_ready = 1'b1; key_len = kl;
    total++;
    if (!fin || nxt != nr + 1 || spurious) begin
      bad++;
      $display("FAIL job_end: got finished=%b keys=%0d early_done=%b, want 1 %0d 0",
               fin, nxt, spurious, nr + 1);
    end
    if (timing) begin
      total++;
      if (first_v != 4 || last_e != 4*nr + 4) begin
        bad++;
        $display("FAIL latency: got first=%0d last=%0d, want first=4 last=%0d",
                 first_v, last_e, 4*nr + 4);
      end
    end
    tick();
    total++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL after_done: got done=%b busy=%b, want 0 0", m_done, m_busy);
    end
  endtask

  task automatic check_idle_zero(input string name);
    total++;
    if (rk_o_a !== 0 || rk_idx_a !== 0 || rk_valid_a !== 0 || rk_last_a !== 0 ||
        busy_a !== 0 || done_a !== 0 || err_a !== 0 ||
        rk_o_b !== 0 || rk_idx_b !== 0 || rk_valid_b !== 0 || rk_last_b !== 0 ||
        busy_b !== 0 || done_b !== 0 || err_b !== 0) begin
      bad++;
      $display("FAIL %s: got a: rk=%h idx=%0d v=%b l=%b b=%b d=%b e=%b / b: rk=%h v=%b b=%b, want all 0",
               name, rk_o_a, rk_idx_a, rk_valid_a, rk_last_a, busy_a, done_a, err_a,
               rk_o_b, rk_valid_b, busy_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b1; key_len = 2'd0; key_i = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset_state");
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_kat128();
    logic [255:0] k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      run_job(k, 2'd0, 0, 1'b1, 1'b0);
      total++;
      if (got_rk[0] !== k[255:128] || got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
        bad++;
        $display("FAIL kat128 build=%0d: got rk0=%h rk10=%h, want rk0=%h rk10=d014f9a8c9ee2589e13f0cc8b6630ca6",
                 s, got_rk[0], got_rk[10], k[255:128]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_kat192();
    logic [255:0] k = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    run_job(k, 2'd1, 0, 1'b1, 1'b0);
    total++;
    if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      bad++;
      $display("FAIL kat192: got rk12=%h, want e98ba06f448c773c8ecc720401002202", got_rk[12]);
    end
  endtask

  task automatic test_kat256();
    logic [255:0] k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    run_job(k, 2'd2, 0, 1'b1, 1'b0);
    total++;
    if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      bad++;
      $display("FAIL kat256: got rk14=%h, want fe4890d1e6188d0b046df344706c631e", got_rk[14]);
    end
  endtask

  task automatic test_backpressure();
    zb_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      sel = n[0];
      run_job(rand_key(), 2'd0, 1, 1'b0, 1'b0);
    end
    sel = 1'b0;
    total++;
    if (zb_cnt == 0) begin
      bad++;
      $display("FAIL zero_bubble: got %0d back-to-back loads, want >0", zb_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) run_job(rand_key(), 2'(n % 3), 1, 1'b0, 1'b0);
  endtask

  task automatic test_start_busy();
    run_job(rand_key(), 2'd0, 0, 1'b1, 1'b1);
    run_job(rand_key(), 2'd1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int n = 0;
    bit saw_done = 1'b0;
    key_len = 2'd2; key_i = rand_key(); start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!(rk_valid_a && rk_idx_a == 4'd5) && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL abort_reach: got no rk_idx=5 within %0d cycles, want it", n);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy_a !== 1'b0 || rk_valid_a !== 1'b0 || rk_last_a !== 1'b0) begin
      bad++;
      $display("FAIL abort: got busy=%b v=%b last=%b, want 0 0 0", busy_a, rk_valid_a, rk_last_a);
    end
    repeat (70) begin
      tick();
      if (done_a !== 1'b0 || busy_a !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL abort_quiet: got done/busy activity after abort, want none");
    end
  endtask

  task automatic test_illegal();
    key_len = 2'd3; key_i = rand_key(); start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (err_a !== 1'b1 || busy_a !== 1'b0 || err_b !== 1'b1 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL illegal_len: got err=%b/%b busy=%b/%b, want 1/1 0/0", err_a, err_b, busy_a, busy_b);
    end
    tick();
    total++;
    if (err_a !== 1'b0 || err_b !== 1'b0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse: got err=%b/%b busy=%b, want 0/0 0", err_a, err_b, busy_a);
    end
    for (int kl = 1; kl <= 2; kl++) begin
      key_len = 2'(kl); start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (err_b !== 1'b1 || busy_b !== 1'b0 || err_a !== 1'b0 || busy_a !== 1'b1) begin
        bad++;
        $display("FAIL max128_len%0d: got err_b=%b busy_b=%b err_a=%b busy_a=%b, want 1 0 0 1",
                 kl, err_b, busy_b, err_a, busy_a);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0) begin
        bad++;
        $display("FAIL idle_abort: got busy=%b/%b err_b=%b, want 0/0 0", busy_a, busy_b, err_b);
      end
    end
  endtask

  task automatic test_async_reset();
    key_len = 2'd1; key_i = rand_key(); start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    total++;
    if (busy_a !== 1'b1 || rk_o_a === 128'h0) begin
      bad++;
      $display("FAIL mid_job: got busy=%b rk=%h, want busy=1 rk nonzero", busy_a, rk_o_a);
    end
    #2 rst = 1'b1;
    #1;
    check_idle_zero("async_reset");
    @(negedge clk) rst = 1'b0;
    tick();
    check_idle_zero("post_reset");
  endtask

  initial begin
    test_reset();
    test_kat128();
    test_kat192();
    test_kat256();
    test_backpressure();
    test_random();
    test_start_busy();
    test_abort();
    test_illegal();
    test_async_reset();
    sel = 1'b1;
    run_job({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd0, 0, 1'b1, 1'b0);
    sel = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Sequential AES key-expansion engine generalised from the single-round AES-128 step to AES-128/192/256, selected per job at start.
- Produces the complete round-key schedule, 4*(Nr+1) words, one 32-bit word per cycle, and emits it as 128-bit round keys over a valid/ready handshake with back-pressure.
- S-box lookup is external and combinational, shared with the datapath S-box.
- Sits between the control unit and the cipher round datapath.

Parameters:
- MAX_KEY_BITS, 256, largest supported key: 128, 192 or 256. key_len modes above this limit are rejected with err.

Ports:
- clk      in   1    clock
- rst      in   1    asynchronous active-high reset
- start    in   1    pulse: launch expansion; sampled only in IDLE
- key_len  in   2    0=AES-128 (Nk=4,Nr=10), 1=AES-192 (Nk=6,Nr=12), 2=AES-256 (Nk=8,Nr=14), 3=illegal
- key_i    in   MAX_KEY_BITS  cipher key, left-aligned; w0 = key_i[MSB -: 32]; unused low bits ignored
- abort    in   1    synchronous cancel
- sub_o    out  32   word presented to external S-box
- sub_i    in   32   SubWord(sub_o), valid in the same cycle
- rk_o     out  128  round key {w4r, w4r+1, w4r+2, w4r+3}, w4r in [127:96]
- rk_idx   out  4    round index r of rk_o (0..Nr)
- rk_valid out  1    rk_o valid
- rk_ready in   1    consumer accepts when rk_valid and rk_ready are both high
- rk_last  out  1    high with rk_valid when rk_idx==Nr
- busy     out  1    high in any state other than IDLE
- done     out  1    one-cycle pulse on acceptance of the last round key
- err      out  1    one-cycle pulse on a rejected start

Behaviour:
- Reset (async, any state): state=IDLE; rk_o=0, rk_idx=0, rk_valid=0, rk_last=0, busy=0, done=0, err=0; word counter, window and Rcon cleared.
- Reset mid-job discards all progress. No output holds a value from before reset.
- FSM states: IDLE, KEYW, EXPAND, FLUSH.
  - IDLE to KEYW: start with a legal key_len. Key, Nk and Nr are latched and Rcon is set to 0x01.
  - KEYW: emits w0..wNk-1 from the latched key, one word per advance. Moves to EXPAND after wNk-1.
  - EXPAND: computes wi for i=Nk..4Nr+3.
  - FLUSH: waits for the last round key to be accepted, then pulses done and returns to IDLE.
- start is ignored when busy. start with key_len=3, or with Nk*32>MAX_KEY_BITS, pulses err and stays IDLE.
- Window: shift register of the last Nk words; wi-Nk is the oldest entry, wi-1 the newest.
- Word generation (i = current word index, combinational temp):
  - i mod Nk==0: sub_o = RotWord(wi-1) = {b1,b2,b3,b0}; temp = sub_i XOR {Rcon,24'h0}. Rcon then advances by xtime: x<<1, XOR 0x1b if bit7 was set.
  - Nk==8 and i mod 8==4: sub_o = wi-1; temp = sub_i.
  - Otherwise: temp = wi-1. sub_o is driven to wi-1 regardless.
  - wi = wi-Nk XOR temp.
- Assembler: 2-bit count c collects words.
  - The 4th word loads rk_o, sets rk_valid and rk_idx = round, and increments round.
- Advance condition (a word is produced and counters move): adv = (c!=3) | ~rk_valid | rk_ready.
  - With adv low, the FSM, window, Rcon and i hold.
  - A round key held under back-pressure keeps rk_o stable until accepted.
- Handshake:
  - Acceptance with no new key clears rk_valid.
  - Acceptance and new-key load in the same cycle keeps rk_valid high with the new data (zero bubble).
- Latency: start sampled at edge E0; words enter at E1..E4; rk_valid rises after E4.
  - With rk_ready held high, round keys follow every 4 cycles.
  - Last round key after edge E(4Nr+4): E44 for AES-128, E52 for AES-192, E60 for AES-256.
- done pulses the cycle after the last-key acceptance edge; busy falls together with done.
- abort (any busy state): next edge returns to IDLE, clears rk_valid, rk_last and counters, and produces no done. abort in IDLE is a no-op. abort wins over simultaneous acceptance.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk0 equals the key.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 at edge 44.
  - done the cycle after; Rcon 0x80 wraps to 0x1b.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk12 = e98ba06f448c773c8ecc720401002202, 13 round keys, done.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk14 = fe4890d1e6188d0b046df344706c631e.
  - Exercises the i mod 8==4 SubWord path.
- Random rk_ready back-pressure on AES-128: identical key sequence, rk_o stable while stalled, no lost or duplicated rk_idx, zero-bubble acceptance observed.
- Mid-job events:
  - start while busy: ignored.
  - abort at rk_idx=5: next cycle busy=0, rk_valid=0, no done.
  - key_len=3: err pulse, busy stays 0.
  - rst asserted asynchronously mid-EXPAND: all outputs 0 immediately.
- MAX_KEY_BITS=128 build: key_len=1 or 2 -> err pulse; key_len=0 behaves as in the first AES-128 scenario.
